// File: rtl/phase_step_ctrl_mc_if.sv
// Control/status bundle for phase_step_ctrl_mc.
// master: button/channel/step/clear/enable driver (board glue or bench).
// slave : the controller; returns per-channel magnitude, direction and pulses.
interface phase_step_ctrl_mc_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned PHASE_W = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                        i_en;
  logic                        i_btn_up;
  logic                        i_btn_dn;
  logic [CH_W-1:0]             i_ch_sel;
  logic [STEP_W-1:0]           i_step;
  logic                        i_clr;
  logic [NUM_CH*PHASE_W-1:0]   o_phase_inc;
  logic [NUM_CH-1:0]           o_dir;
  logic                        o_upd;
  logic                        o_sat;

  modport master (
    output i_en, i_btn_up, i_btn_dn, i_ch_sel, i_step, i_clr,
    input  o_phase_inc, o_dir, o_upd, o_sat
  );

  modport slave (
    input  i_en, i_btn_up, i_btn_dn, i_ch_sel, i_step, i_clr,
    output o_phase_inc, o_dir, o_upd, o_sat
  );
endinterface

// File: rtl/phase_step_ctrl_mc.sv
// Multi-channel phase-increment controller. One saturating signed accumulator
// per channel, adjusted from active-low up/down buttons with press-and-hold
// auto-repeat. Each channel is presented as |acc| plus a sign bit.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport):
//   i_en, i_btn_up, i_btn_dn, i_ch_sel, i_step, i_clr in;
//   o_phase_inc, o_dir, o_upd, o_sat out (all registered).
module phase_step_ctrl_mc #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned STEP_W        = 8,
  parameter int unsigned PHASE_W       = 16,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  phase_step_ctrl_mc_if.slave   bus
);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W   = PHASE_W + 1;
  localparam int unsigned SUM_W   = PHASE_W + 2;
  localparam int unsigned DLT_W   = STEP_W + 1;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic signed [SUM_W-1:0] POS_LIM = {2'b00, {PHASE_W{1'b1}}};
  localparam logic signed [SUM_W-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_LOCK} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       lat_up_q, lat_up_d;
  logic [CH_W-1:0]            lat_ch_q, lat_ch_d;
  logic [STEP_W-1:0]          lat_step_q, lat_step_d;
  logic [1:0]                 up_sync_q, dn_sync_q;
  logic signed [ACC_W-1:0]    acc_q [NUM_CH];
  logic [NUM_CH-1:0][PHASE_W-1:0] phase_q;
  logic [NUM_CH-1:0]          dir_q;
  logic                       wr_q, sat_pend_q, upd_q, sat_q;

  logic                       up_s, dn_s, held_c, go_c;
  logic signed [DLT_W-1:0]    step_ext_c, delta_c;
  logic signed [ACC_W-1:0]    acc_sel_c, clamp_c;
  logic signed [SUM_W-1:0]    sum_c;
  logic                       clamp_hit_c;
  logic [NUM_CH-1:0]          clr_hit_c, step_hit_c;
  logic [NUM_CH-1:0][PHASE_W-1:0] mag_c;

  // Two-flop synchronizers; reset to "released" so a held button after
  // reset release is seen as a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      up_sync_q <= 2'b11;
      dn_sync_q <= 2'b11;
    end else begin
      up_sync_q <= {up_sync_q[0], bus.i_btn_up};
      dn_sync_q <= {dn_sync_q[0], bus.i_btn_dn};
    end
  end

  assign up_s   = ~up_sync_q[1];
  assign dn_s   = ~dn_sync_q[1];
  assign held_c = lat_up_q ? up_s : dn_s;

  // FSM state, shared hold/repeat counter and press-time latches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lat_up_q   <= 1'b0;
      lat_ch_q   <= '0;
      lat_step_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_up_q   <= lat_up_d;
      lat_ch_q   <= lat_ch_d;
      lat_step_q <= lat_step_d;
    end
  end

  // Next state; in IDLE the latch inputs pass through so the first step uses
  // the values present at the press.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_up_d   = lat_up_q;
    lat_ch_d   = lat_ch_q;
    lat_step_d = lat_step_q;
    go_c       = 1'b0;
    if (!bus.i_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (up_s && dn_s) begin
            state_d = S_LOCK;
          end else if (up_s || dn_s) begin
            go_c       = 1'b1;
            lat_up_d   = up_s;
            lat_ch_d   = bus.i_ch_sel;
            lat_step_d = bus.i_step;
            cnt_d      = '0;
            state_d    = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (!held_c) begin
            state_d = S_IDLE;
          end else if (up_s && dn_s) begin
            state_d = S_LOCK;
          end else if (cnt_q == ((state_q == S_HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                                     : CNT_W'(REPEAT_CYCLES - 1))) begin
            go_c    = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_LOCK: begin
          if (!up_s && !dn_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Step arithmetic with symmetric clamp; delta is one bit wider than the
  // step so negating the most-negative step cannot overflow.
  always_comb begin
    acc_sel_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (lat_ch_d == CH_W'(k)) acc_sel_c = acc_q[k];
      clr_hit_c[k]  = bus.i_clr && (bus.i_ch_sel == CH_W'(k));
      step_hit_c[k] = go_c && (lat_ch_d == CH_W'(k));
      mag_c[k]      = acc_q[k][ACC_W-1] ? PHASE_W'(-acc_q[k]) : acc_q[k][PHASE_W-1:0];
    end
    step_ext_c  = {lat_step_d[STEP_W-1], lat_step_d};
    delta_c     = lat_up_d ? step_ext_c : -step_ext_c;
    sum_c       = SUM_W'(acc_sel_c) + SUM_W'(delta_c);
    clamp_hit_c = 1'b0;
    clamp_c     = sum_c[ACC_W-1:0];
    if (sum_c > POS_LIM) begin
      clamp_c     = POS_LIM[ACC_W-1:0];
      clamp_hit_c = 1'b1;
    end else if (sum_c < NEG_LIM) begin
      clamp_c     = NEG_LIM[ACC_W-1:0];
      clamp_hit_c = 1'b1;
    end
  end

  // Accumulators (clear beats a step to the same channel) and output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(NUM_CH); k++) acc_q[k] <= '0;
      phase_q    <= '0;
      dir_q      <= '0;
      wr_q       <= 1'b0;
      sat_pend_q <= 1'b0;
      upd_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (clr_hit_c[k])       acc_q[k] <= '0;
        else if (step_hit_c[k]) acc_q[k] <= clamp_c;
        dir_q[k] <= acc_q[k][ACC_W-1];
      end
      phase_q    <= mag_c;
      wr_q       <= (|clr_hit_c) || (|step_hit_c);
      sat_pend_q <= clamp_hit_c && (|(step_hit_c & ~clr_hit_c));
      upd_q      <= wr_q;
      sat_q      <= sat_pend_q;
    end
  end

  assign bus.o_phase_inc = phase_q;
  assign bus.o_dir       = dir_q;
  assign bus.o_upd       = upd_q;
  assign bus.o_sat       = sat_q;
endmodule

// File: tb/tb_phase_step_ctrl_mc.sv
// Scoreboard bench for phase_step_ctrl_mc: stimulus pushes the expected
// {cycle, magnitudes, dirs, sat} of each update; a negedge monitor pops and
// compares on every o_upd pulse and flags any unexpected pulse.
module tb_phase_step_ctrl_mc;
  localparam int unsigned NUM_CH = 2, STEP_W = 4, PHASE_W = 8;
  localparam int unsigned HOLD = 10, REP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  phase_step_ctrl_mc_if #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .PHASE_W(PHASE_W)) bus ();

  phase_step_ctrl_mc #(
    .NUM_CH(NUM_CH), .STEP_W(STEP_W), .PHASE_W(PHASE_W),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] ph;
    logic [1:0]  dir;
    logic        sat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic exp_push(input int c, input int p0, input int p1,
                          input logic [1:0] d, input logic s);
    exp_t e;
    e.cyc = c;
    e.ph  = {8'(p1), 8'(p0)};
    e.dir = d;
    e.sat = s;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic up, input int ch, input logic [3:0] st, input int h);
    bus.i_ch_sel = 1'(ch);
    bus.i_step   = st;
    if (up) bus.i_btn_up = 1'b0;
    else    bus.i_btn_dn = 1'b0;
    tick(h);
    bus.i_btn_up = 1'b1;
    bus.i_btn_dn = 1'b1;
  endtask

  // Monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_upd) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_upd: cyc=%0d phase=%h dir=%b sat=%b, required no update",
                 cyc, bus.o_phase_inc, bus.o_dir, bus.o_sat);
      end else begin
        mon_e = q.pop_front();
        if (cyc != mon_e.cyc || bus.o_phase_inc !== mon_e.ph ||
            bus.o_dir !== mon_e.dir || bus.o_sat !== mon_e.sat) begin
          n_fail++;
          $display("FAIL upd_check: got cyc=%0d phase=%h dir=%b sat=%b, required cyc=%0d phase=%h dir=%b sat=%b",
                   cyc, bus.o_phase_inc, bus.o_dir, bus.o_sat,
                   mon_e.cyc, mon_e.ph, mon_e.dir, mon_e.sat);
        end
      end
    end
  end

  initial begin
    int b;
    bus.i_en     = 1'b1;
    bus.i_btn_up = 1'b1;
    bus.i_btn_dn = 1'b1;
    bus.i_ch_sel = '0;
    bus.i_step   = '0;
    bus.i_clr    = 1'b0;

    // Reset values
    tick(3);
    chk("rst_phase", 32'(bus.o_phase_inc), 32'd0);
    chk("rst_dir",   32'(bus.o_dir), 32'd0);
    chk("rst_upd",   32'(bus.o_upd), 32'd0);
    chk("rst_sat",   32'(bus.o_sat), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Basic up +3 then down 5 on ch0: 3, then -2
    b = cyc; exp_push(b + 4, 3, 0, 2'b00, 1'b0);
    press(1'b1, 0, 4'd3, 3); tick(5);
    b = cyc; exp_push(b + 4, 2, 0, 2'b01, 1'b0);
    press(1'b0, 0, 4'd5, 3); tick(5);

    // Plain clear of ch0
    b = cyc; exp_push(b + 2, 0, 0, 2'b00, 1'b0);
    bus.i_ch_sel = 1'b0; bus.i_clr = 1'b1; tick(1); bus.i_clr = 1'b0; tick(5);

    // Auto-repeat, step 1 held 30 cycles: steps at t0,+10,+14,+18,+22,+26
    b = cyc;
    exp_push(b + 4, 1, 0, 2'b00, 1'b0);
    for (int k = 2; k <= 6; k++) exp_push(b + 14 + 4 * (k - 2), k, 0, 2'b00, 1'b0);
    press(1'b1, 0, 4'd1, 30); tick(10);

    // ch1: down with step -8 applies +8; 31 steps via auto-repeat -> 248
    b = cyc;
    exp_push(b + 4, 6, 8, 2'b00, 1'b0);
    for (int k = 2; k <= 31; k++) exp_push(b + 14 + 4 * (k - 2), 6, 8 * k, 2'b00, 1'b0);
    press(1'b0, 1, 4'b1000, 128); tick(10);
    b = cyc; exp_push(b + 4, 6, 250, 2'b00, 1'b0);
    press(1'b1, 1, 4'd2, 3); tick(5);

    // Saturation at 255, twice
    b = cyc; exp_push(b + 4, 6, 255, 2'b00, 1'b1);
    press(1'b1, 1, 4'd7, 3); tick(5);
    b = cyc; exp_push(b + 4, 6, 255, 2'b00, 1'b1);
    press(1'b1, 1, 4'd7, 3); tick(5);

    // LOCK: up held, down added, down released, then both released
    b = cyc; exp_push(b + 4, 7, 255, 2'b00, 1'b0);
    bus.i_ch_sel = 1'b0; bus.i_step = 4'd1; bus.i_btn_up = 1'b0;
    tick(5);  bus.i_btn_dn = 1'b0;
    tick(20); bus.i_btn_dn = 1'b1;
    tick(20); bus.i_btn_up = 1'b1;
    tick(10);
    b = cyc; exp_push(b + 4, 8, 255, 2'b00, 1'b0);
    press(1'b1, 0, 4'd1, 3); tick(5);

    // Clear beats a saturating step on the same channel (ch1)
    b = cyc; exp_push(b + 4, 8, 0, 2'b00, 1'b0);
    bus.i_ch_sel = 1'b1; bus.i_step = 4'd7; bus.i_btn_up = 1'b0;
    tick(2); bus.i_clr = 1'b1;
    tick(1); bus.i_clr = 1'b0; bus.i_btn_up = 1'b1;
    tick(5);

    // Repeat step on latched ch1 coincides with clear of ch0; mid-hold
    // changes to ch_sel/step are ignored
    b = cyc;
    exp_push(b + 4, 8, 2, 2'b00, 1'b0);
    exp_push(b + 14, 0, 4, 2'b00, 1'b0);
    bus.i_ch_sel = 1'b1; bus.i_step = 4'd2; bus.i_btn_up = 1'b0;
    tick(5); bus.i_ch_sel = 1'b0; bus.i_step = 4'd7;
    tick(7); bus.i_clr = 1'b1; bus.i_btn_up = 1'b1;
    tick(1); bus.i_clr = 1'b0;
    tick(6);

    // Enable low: press ignored
    bus.i_en = 1'b0;
    press(1'b1, 0, 4'd1, 3); tick(6);
    bus.i_en = 1'b1; tick(3);

    // Async reset in REPEAT, then release with up still held
    b = cyc;
    exp_push(b + 4, 1, 4, 2'b00, 1'b0);
    exp_push(b + 14, 2, 4, 2'b00, 1'b0);
    exp_push(b + 18, 3, 4, 2'b00, 1'b0);
    bus.i_ch_sel = 1'b0; bus.i_step = 4'd1; bus.i_btn_up = 1'b0;
    tick(19);
    rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(bus.o_phase_inc), 32'd0);
    chk("arst_dir",   32'(bus.o_dir), 32'd0);
    chk("arst_upd",   32'(bus.o_upd), 32'd0);
    tick(3);
    rst_n = 1'b1;
    exp_push(b + 26, 1, 0, 2'b00, 1'b0);
    tick(8); bus.i_btn_up = 1'b1;
    tick(10);

    chk("pending_updates", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/phase_step_ctrl_mc.md
# phase_step_ctrl_mc

Multi-channel phase-increment controller for the DDS wave/noise generators. Keeps one saturating signed step accumulator per channel. Adjusts the selected channel from up/down push-buttons, with press-and-hold auto-repeat. Each channel drives its phase generator as a magnitude plus a direction bit.

## Interface
- NUM_CH, 4: number of channels (≥1); CH_W = max(1, $clog2(NUM_CH)).
- STEP_W, 8: width of signed step input.
- PHASE_W, 16: magnitude width per channel; accumulator is PHASE_W+1 bits signed.
- HOLD_CYCLES, 25_000_000: cycles a button must stay pressed before auto-repeat begins (≥2).
- REPEAT_CYCLES, 5_000_000: cycles between auto-repeat steps (≥2).
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  adjust enable; low forces FSM to IDLE, accumulators hold.
- i_btn_up  in  1  raw push-button, active-low, asynchronous to i_clk.
- i_btn_dn  in  1  raw push-button, active-low, asynchronous to i_clk.
- i_ch_sel  in  CH_W  channel to adjust; latched at press.
- i_step  in  STEP_W  signed step; up adds it, down subtracts it; latched at press.
- i_clr  in  1  synchronous clear of channel i_ch_sel accumulator.
- o_phase_inc  out  NUM_CH*PHASE_W  per-channel |acc|; channel k at bits [k*PHASE_W +: PHASE_W].
- o_dir  out  NUM_CH  per-channel sign (1 = acc negative).
- o_upd  out  1  one-cycle pulse when any output register was rewritten.
- o_sat  out  1  one-cycle pulse, coincident with o_upd, when the applied step was clamped.

## Operation
- Each button passes through a 2-FF synchronizer and is inverted to active-high: up_s, dn_s.
- FSM states: IDLE, HOLD, REPEAT, LOCK. A single counter is shared by HOLD and REPEAT.
- IDLE:
  - Exactly one of up_s/dn_s high → issue step, latch dir/channel/step, clear counter, go HOLD.
  - Both high → go LOCK.
- HOLD:
  - Latched button released → IDLE.
  - Both high → LOCK.
  - Counter reaches HOLD_CYCLES-1 → issue step, clear counter, go REPEAT.
- REPEAT:
  - Latched button released → IDLE.
  - Both high → LOCK.
  - Counter reaches REPEAT_CYCLES-1 → issue step, clear counter.
- LOCK: no steps; go IDLE only when both up_s and dn_s are low.
- i_en low: next state IDLE from any state; no step issued.
- Step arithmetic:
  - delta = sign-extended step, negated for down. Computed in STEP_W+1 bits, so negating the most-negative step does not overflow.
  - sum = acc + delta, computed in PHASE_W+2 bits.
  - Clamp sum to [-(2^PHASE_W-1), +(2^PHASE_W-1)]; o_sat flags a clamp.
- Output registers: o_phase_inc[k] = |acc[k]|, o_dir[k] = acc[k] < 0. Both are registered one cycle after the accumulator write.
- i_clr has priority over a step to the same channel in the same cycle. That step is dropped and o_sat stays 0.
- A step to a different channel coinciding with i_clr proceeds normally.
- Changing i_ch_sel or i_step while a button is held has no effect until the next press.

## Timing
- Reset values: all accumulators 0, o_phase_inc 0, o_dir 0, o_upd 0, o_sat 0, FSM IDLE, counter 0.
- Press latency: button low sampled at edge E → up_s high after E+1 → accumulator written at E+2 → o_phase_inc/o_dir/o_upd valid after E+3.
- Auto-repeat: first repeat step issued HOLD_CYCLES cycles after the initial step; subsequent steps every REPEAT_CYCLES cycles.
- Clear latency: i_clr sampled at edge C → outputs 0 after C+1, o_upd pulses.
- Asynchronous reset mid-hold returns everything to reset values immediately. A still-pressed button after reset release counts as a new press; no step is lost or duplicated.

## Test plan
- Reset and basic step (PHASE_W=8, STEP_W=4, NUM_CH=2):
  - Reset → all outputs 0.
  - ch0, step=+3, one up press → ch0 mag 3, dir 0, o_upd one pulse at press+3 edges.
  - One down press, step=5 → ch0 mag 2, dir 1.
- Saturation and extreme step:
  - ch1 at 250, up step=+7 → mag 255, o_sat=1.
  - Repeat the press → still 255, o_sat=1.
  - step=-8 with down → +8 applied, no overflow.
- Auto-repeat (HOLD_CYCLES=10, REPEAT_CYCLES=4):
  - Hold up for 30 cycles with step=1 → steps at t0, t0+10, t0+14, t0+18, t0+22, t0+26 → final mag 6.
  - Release mid-hold → steps stop.
- Both buttons (LOCK):
  - Press up, then down while held → no further steps.
  - Release down only → still no steps.
  - Release both, then press up → one step.
- Clear priority:
  - i_clr on ch0 in the same cycle a ch0 step would apply → ch0=0, o_sat=0.
  - Same with step on ch1 → ch1 updated, ch0 cleared.
- Enable and async reset:
  - i_en=0 during press → no change.
  - Assert i_rst_n low in REPEAT → outputs 0 immediately.
  - Release reset with up held → exactly one step after sync latency.
